cycle_ctrl: RTL and testbench
=============================

CYCLE_CTRL -- requirements
Module: cycle_ctrl

Interface
REQ-001 Parameter: RESET_PC, 4'd0, P_COUNT value loaded by reset.
REQ-002 Parameter: CNT_W, 8, width of the RETIRED counter.
REQ-003 Port: CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: RESET  input  1  asynchronous, active-high reset.
REQ-005 Port: START  input  1  run request; sampled only in IDLE or HALT.
REQ-006 Port: STEP_MODE  input  1  level; 1 = return to IDLE after each instruction.
REQ-007 Port: JMP_EN  input  1  jump request from execute stage; sampled only in EX.
REQ-008 Port: JMP_ADDR  input  4  jump target; sampled with JMP_EN.
REQ-009 Port: HALT_REQ  input  1  halt request from execute stage; sampled only in EX.
REQ-010 Port: P_COUNT  output  4  program counter to the fetch stage (program ROM address).
REQ-011 Port: EN_FT, EN_DC, EN_EX, EN_WB  output  1 each  stage enables, at most one high per cycle.
REQ-012 Port: PHASE  output  2  current stage (0=FT, 1=DC, 2=EX, 3=WB); 0 in IDLE/HALT.
REQ-013 Port: BUSY  output  1  high in FT, DC, EX and WB.
REQ-014 Port: HALTED  output  1  high only in HALT.
REQ-015 Port: RETIRED  output  CNT_W  count of completed WB cycles.

Function
REQ-016 States SHALL be IDLE, FT, DC, EX, WB, HALT; all outputs SHALL be driven from registered state only, with no combinational input-to-output path.
REQ-017 IDLE: START=1 at an edge -> FT; otherwise remain in IDLE.
REQ-018 FT -> DC -> EX -> WB unconditionally, one cycle each; EN_FT, EN_DC, EN_EX, EN_WB SHALL be high exactly during FT, DC, EX and WB respectively.
REQ-019 Latency: START sampled at edge k -> EN_FT high in the cycle after edge k; one instruction occupies 4 cycles.
REQ-020 In EX, JMP_EN, JMP_ADDR and HALT_REQ SHALL be latched at the EX->WB edge; values presented in any other state SHALL be ignored.
REQ-021 At the WB exit edge, P_COUNT SHALL take the latched JMP_ADDR if a jump was latched, else P_COUNT+1 modulo 16 (15 wraps to 0).
REQ-022 P_COUNT SHALL be stable from FT through WB of each instruction.
REQ-023 At the WB exit edge, RETIRED SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-024 WB exit priority: halt latched -> HALT; else STEP_MODE=1 -> IDLE; else -> FT.
REQ-025 Simultaneous jump and halt in one EX: P_COUNT SHALL take the jump target, then enter HALT.
REQ-026 HALT: HALTED=1; START=1 -> FT with P_COUNT unchanged and HALTED cleared on the same edge; otherwise remain in HALT.
REQ-027 START while BUSY SHALL be ignored, with no effect on the state sequence or counters.
REQ-028 STEP_MODE SHALL be sampled only at the WB exit edge; changing it mid-instruction SHALL NOT shorten the instruction.
REQ-029 The jump and halt latches SHALL clear at the WB exit edge.

Reset
REQ-030 RESET=1 SHALL force IDLE immediately and asynchronously: P_COUNT=RESET_PC; EN_* = 0; PHASE=0; BUSY=0; HALTED=0; RETIRED=0; jump and halt latches cleared.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction without a P_COUNT or RETIRED update.
REQ-032 After reset release, the block SHALL stay in IDLE until START is sampled high.

Verification
REQ-033 Free run: reset, STEP_MODE=0, START pulse, no JMP/HALT for 64 cycles -> EN_FT..EN_WB rotate; P_COUNT sequence 0,1,…,15,0,…; P_COUNT 15 wraps to 0 after the 16th WB; RETIRED=16.
REQ-034 Jump: JMP_EN=1, JMP_ADDR=4'hA during EX of instruction at P_COUNT=3 -> next FT shows P_COUNT=10; JMP_EN pulsed during DC has no effect.
REQ-035 Halt+jump: HALT_REQ=1 and JMP_EN=1, JMP_ADDR=4'h2 in the same EX -> HALTED=1 after WB, P_COUNT=2, BUSY=0; START -> FT with P_COUNT=2.
REQ-036 Single step: STEP_MODE=1, START pulse -> exactly 4 busy cycles, then IDLE with P_COUNT=1 and RETIRED=1; START held high during busy cycles is ignored.
REQ-037 Mid-op reset: RESET asserted asynchronously in EX with a jump pending -> outputs are reset values immediately with no edge; after release and START, P_COUNT=0.
REQ-038 Saturation: CNT_W=2, run 6 instructions -> RETIRED sticks at 3.

Source files
------------

// File: rtl/cycle_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and its surroundings.
// The master side drives the run/jump/halt requests; the slave (cycle_ctrl) drives status.
interface cycle_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             START;
    logic             STEP_MODE;
    logic             JMP_EN;
    logic [3:0]       JMP_ADDR;
    logic             HALT_REQ;
    logic [3:0]       P_COUNT;
    logic             EN_FT;
    logic             EN_DC;
    logic             EN_EX;
    logic             EN_WB;
    logic [1:0]       PHASE;
    logic             BUSY;
    logic             HALTED;
    logic [CNT_W-1:0] RETIRED;

    modport master (
        output START, STEP_MODE, JMP_EN, JMP_ADDR, HALT_REQ,
        input  P_COUNT, EN_FT, EN_DC, EN_EX, EN_WB, PHASE, BUSY, HALTED, RETIRED
    );

    modport slave (
        input  START, STEP_MODE, JMP_EN, JMP_ADDR, HALT_REQ,
        output P_COUNT, EN_FT, EN_DC, EN_EX, EN_WB, PHASE, BUSY, HALTED, RETIRED
    );
endinterface

// File: rtl/cycle_ctrl.sv
// Four-stage instruction sequencer: steps FT/DC/EX/WB, owns the program counter,
// applies jumps and halts latched in EX, and counts retired instructions.
module cycle_ctrl #(
    parameter logic [3:0] RESET_PC = 4'd0,
    parameter int         CNT_W    = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    cycle_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FT   = 3'd1,
        S_DC   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RET_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             jmp_q, jmp_d;
    logic [3:0]       jaddr_q, jaddr_d;
    logic             halt_q, halt_d;
    logic             en_ft_q, en_ft_d;
    logic             en_dc_q, en_dc_d;
    logic             en_ex_q, en_ex_d;
    logic             en_wb_q, en_wb_d;
    logic [1:0]       phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;

    // Next-state, PC/counter update and output decode of the upcoming state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        jmp_d     = jmp_q;
        jaddr_d   = jaddr_q;
        halt_d    = halt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) state_d = S_FT;
                else           state_d = S_IDLE;
            end
            S_FT: state_d = S_DC;
            S_DC: state_d = S_EX;
            S_EX: begin
                state_d = S_WB;
                jmp_d   = bus.JMP_EN;
                jaddr_d = bus.JMP_ADDR;
                halt_d  = bus.HALT_REQ;
            end
            S_WB: begin
                if (jmp_q) pc_d = jaddr_q;
                else       pc_d = pc_q + 4'd1;
                if (retired_q == RET_MAX) retired_d = retired_q;
                else                      retired_d = retired_q + RET_ONE;
                jmp_d   = 1'b0;
                jaddr_d = 4'd0;
                halt_d  = 1'b0;
                // A latched halt wins over single-step, which wins over free run
                if (halt_q)             state_d = S_HALT;
                else if (bus.STEP_MODE) state_d = S_IDLE;
                else                    state_d = S_FT;
            end
            S_HALT: begin
                if (bus.START) state_d = S_FT;
                else           state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

        en_ft_d  = 1'b0;
        en_dc_d  = 1'b0;
        en_ex_d  = 1'b0;
        en_wb_d  = 1'b0;
        phase_d  = 2'd0;
        busy_d   = 1'b0;
        halted_d = 1'b0;
        case (state_d)
            S_FT:   begin en_ft_d = 1'b1; phase_d = 2'd0; busy_d = 1'b1; end
            S_DC:   begin en_dc_d = 1'b1; phase_d = 2'd1; busy_d = 1'b1; end
            S_EX:   begin en_ex_d = 1'b1; phase_d = 2'd2; busy_d = 1'b1; end
            S_WB:   begin en_wb_d = 1'b1; phase_d = 2'd3; busy_d = 1'b1; end
            S_HALT: halted_d = 1'b1;
            default: halted_d = 1'b0;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            retired_q <= {CNT_W{1'b0}};
            jmp_q     <= 1'b0;
            jaddr_q   <= 4'd0;
            halt_q    <= 1'b0;
            en_ft_q   <= 1'b0;
            en_dc_q   <= 1'b0;
            en_ex_q   <= 1'b0;
            en_wb_q   <= 1'b0;
            phase_q   <= 2'd0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            jmp_q     <= jmp_d;
            jaddr_q   <= jaddr_d;
            halt_q    <= halt_d;
            en_ft_q   <= en_ft_d;
            en_dc_q   <= en_dc_d;
            en_ex_q   <= en_ex_d;
            en_wb_q   <= en_wb_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.P_COUNT = pc_q;
    assign bus.EN_FT   = en_ft_q;
    assign bus.EN_DC   = en_dc_q;
    assign bus.EN_EX   = en_ex_q;
    assign bus.EN_WB   = en_wb_q;
    assign bus.PHASE   = phase_q;
    assign bus.BUSY    = busy_q;
    assign bus.HALTED  = halted_q;
    assign bus.RETIRED = retired_q;

endmodule

// File: tb/tb_cycle_ctrl.sv
// Bench for cycle_ctrl: instruction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations (second DUT with CNT_W=2).
module tb_cycle_ctrl;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cycle_ctrl_if #(.CNT_W(8)) bus ();
    cycle_ctrl_if #(.CNT_W(2)) bus2 ();

    cycle_ctrl #(.RESET_PC(4'd0), .CNT_W(8)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    cycle_ctrl #(.RESET_PC(4'd0), .CNT_W(2)) dut2 (.CLK(CLK), .RESET(RESET), .bus(bus2));

    assign bus2.START     = bus.START;
    assign bus2.STEP_MODE = bus.STEP_MODE;
    assign bus2.JMP_EN    = bus.JMP_EN;
    assign bus2.JMP_ADDR  = bus.JMP_ADDR;
    assign bus2.HALT_REQ  = bus.HALT_REQ;

    always #5 CLK = ~CLK;

    // Reference model: m_pos is the position inside the current instruction (-1 = not running)
    int         m_pos;
    bit         m_halted;
    logic [3:0] m_pc;
    int         m_ret;
    bit         m_j;
    bit         m_h;
    logic [3:0] m_ja;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_pos <= -1; m_halted <= 1'b0; m_pc <= 4'd0; m_ret <= 0;
            m_j <= 1'b0; m_h <= 1'b0; m_ja <= 4'd0;
        end else if (m_pos < 0) begin
            if (bus.START) begin
                m_pos    <= 0;
                m_halted <= 1'b0;
            end
        end else if (m_pos < 3) begin
            m_pos <= m_pos + 1;
            if (m_pos == 2) begin
                m_j  <= bus.JMP_EN;
                m_h  <= bus.HALT_REQ;
                m_ja <= bus.JMP_ADDR;
            end
        end else begin
            m_pc     <= m_j ? m_ja : 4'((int'(m_pc) + 1) % 16);
            m_ret    <= (m_ret < 255) ? m_ret + 1 : m_ret;
            m_pos    <= (m_h || bus.STEP_MODE) ? -1 : 0;
            m_halted <= m_h;
            m_j      <= 1'b0;
            m_h      <= 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("pc",      int'(bus.P_COUNT), int'(m_pc));
        chk("en_ft",   int'(bus.EN_FT),   int'(m_pos == 0));
        chk("en_dc",   int'(bus.EN_DC),   int'(m_pos == 1));
        chk("en_ex",   int'(bus.EN_EX),   int'(m_pos == 2));
        chk("en_wb",   int'(bus.EN_WB),   int'(m_pos == 3));
        chk("phase",   int'(bus.PHASE),   (m_pos < 0) ? 0 : m_pos);
        chk("busy",    int'(bus.BUSY),    int'(m_pos >= 0));
        chk("halted",  int'(bus.HALTED),  int'(m_halted));
        chk("retired", int'(bus.RETIRED), m_ret);
        chk("sat_ret", int'(bus2.RETIRED), (m_ret > 3) ? 3 : m_ret);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.START = 1'b0; bus.STEP_MODE = 1'b0; bus.JMP_EN = 1'b0;
        bus.JMP_ADDR = 4'd0; bus.HALT_REQ = 1'b0;
        #1 RESET = 1'b1;
        #2;
        chk("rst_pc",   int'(bus.P_COUNT), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_ret",  int'(bus.RETIRED), 0);
        @(negedge CLK); RESET = 1'b0;
        cyc(3);
        chk("idle_wait", int'(bus.BUSY), 0);

        // Single step with START held through the busy cycles
        bus.STEP_MODE = 1'b1; bus.START = 1'b1;
        cyc(1);
        chk("step_ft", int'(bus.EN_FT), 1);
        cyc(2);
        chk("step_busy", int'(bus.BUSY), 1);
        cyc(1); bus.START = 1'b0;
        chk("step_wb", int'(bus.EN_WB), 1);
        cyc(1);
        chk("step_idle", int'(bus.BUSY), 0);
        chk("step_pc",   int'(bus.P_COUNT), 1);
        chk("step_ret",  int'(bus.RETIRED), 1);
        cyc(1);
        chk("step_stay", int'(bus.BUSY), 0);

        // Free run from reset: 16 instructions, PC wraps, narrow counter saturates
        RESET = 1'b1; cyc(1); RESET = 1'b0;
        bus.STEP_MODE = 1'b0; bus.START = 1'b1;
        cyc(1); bus.START = 1'b0;
        cyc(24);
        chk("run_ret6", int'(bus.RETIRED), 6);
        chk("sat_ret6", int'(bus2.RETIRED), 3);
        cyc(36);
        chk("run_pc15", int'(bus.P_COUNT), 15);
        cyc(4);
        chk("run_wrap", int'(bus.P_COUNT), 0);
        chk("run_ret16", int'(bus.RETIRED), 16);
        chk("run_ft", int'(bus.EN_FT), 1);
        bus.STEP_MODE = 1'b1;
        cyc(4);
        chk("run_stop_pc", int'(bus.P_COUNT), 1);
        chk("run_stop_ret", int'(bus.RETIRED), 17);

        // Jump: DC pulse ignored, EX jump at PC=3 lands on 10
        bus.STEP_MODE = 1'b0; bus.START = 1'b1;
        cyc(1); bus.START = 1'b0;
        cyc(5); bus.JMP_EN = 1'b1; bus.JMP_ADDR = 4'd5;
        cyc(1); bus.JMP_EN = 1'b0;
        cyc(2);
        chk("dc_jmp_ignored", int'(bus.P_COUNT), 3);
        cyc(2); bus.JMP_EN = 1'b1; bus.JMP_ADDR = 4'hA;
        cyc(1); bus.JMP_EN = 1'b0;
        chk("jmp_pc_stable", int'(bus.P_COUNT), 3);
        cyc(1);
        chk("jmp_pc", int'(bus.P_COUNT), 10);
        bus.STEP_MODE = 1'b1;
        cyc(4);
        chk("jmp_ret", int'(bus.RETIRED), 21);

        // Halt together with jump, then restart from HALT
        bus.STEP_MODE = 1'b0; bus.START = 1'b1;
        cyc(1); bus.START = 1'b0;
        cyc(2); bus.HALT_REQ = 1'b1; bus.JMP_EN = 1'b1; bus.JMP_ADDR = 4'h2;
        cyc(1); bus.HALT_REQ = 1'b0; bus.JMP_EN = 1'b0;
        cyc(1);
        chk("halt_flag", int'(bus.HALTED), 1);
        chk("halt_pc",   int'(bus.P_COUNT), 2);
        chk("halt_busy", int'(bus.BUSY), 0);
        cyc(1);
        chk("halt_stay", int'(bus.HALTED), 1);
        bus.START = 1'b1;
        cyc(1); bus.START = 1'b0;
        chk("resume_ft", int'(bus.EN_FT), 1);
        chk("resume_pc", int'(bus.P_COUNT), 2);
        chk("resume_halted", int'(bus.HALTED), 0);

        // Asynchronous reset in EX with a jump pending
        cyc(2); bus.JMP_EN = 1'b1; bus.JMP_ADDR = 4'd9;
        #2 RESET = 1'b1;
        #1;
        chk("arst_pc",   int'(bus.P_COUNT), 0);
        chk("arst_ex",   int'(bus.EN_EX), 0);
        chk("arst_busy", int'(bus.BUSY), 0);
        chk("arst_ret",  int'(bus.RETIRED), 0);
        @(negedge CLK); RESET = 1'b0; bus.JMP_EN = 1'b0;
        cyc(2);
        chk("arst_idle", int'(bus.BUSY), 0);
        bus.STEP_MODE = 1'b1; bus.START = 1'b1;
        cyc(1); bus.START = 1'b0;
        chk("arst_start_pc", int'(bus.P_COUNT), 0);
        chk("arst_start_ft", int'(bus.EN_FT), 1);
        cyc(4);
        chk("arst_step_pc", int'(bus.P_COUNT), 1);
        chk("arst_step_ret", int'(bus.RETIRED), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
